// File: rtl/sevenseg_mux_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sevenseg_mux_decoder : filters a multiplexed 7-seg bus, decodes, pairs digits
// Revision 1.0
// ============================================================================
module sevenseg_mux_decoder #(
   parameter int         SETTLE_CYC  = 1,
   parameter int         TIMEOUT_CYC = 1024,
   parameter logic [3:0] BLANK_CODE  = 4'hF,
   parameter logic [3:0] ERR_CODE    = 4'hE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] seg_in,
   output logic [3:0] tens_out,
   output logic [3:0] ones_out,
   output logic       value_valid,
   output logic       update_pulse,
   output logic       bad_pulse,
   output logic [7:0] bad_count
);

   localparam int c_SW = $clog2(SETTLE_CYC + 1);
   localparam int c_IW = $clog2(TIMEOUT_CYC);
   localparam logic [c_SW-1:0] c_SETTLE_MAX = c_SW'(SETTLE_CYC);
   localparam logic [c_SW-1:0] c_SETTLE_ACC = c_SW'(SETTLE_CYC - 1);
   localparam logic [c_IW-1:0] c_IDLE_MAX   = c_IW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HAVE_T = 2'd1,
      S_HAVE_O = 2'd2,
      S_VALID  = 2'd3
   } state_t;

   logic [7:0]      r_seg_q;
   logic [c_SW-1:0] r_stab_cnt;
   logic [c_IW-1:0] r_idle_cnt;
   state_t          r_state;
   state_t          w_next;
   logic [3:0]      r_tens, r_ones, w_code;
   logic            r_valid, r_upd, r_bad, w_upd;
   logic [7:0]      r_bad_cnt;
   logic            w_accept, w_timeout, w_sel;

   assign w_sel     = seg_in[7];
   assign w_accept  = (seg_in == r_seg_q) && (r_stab_cnt == c_SETTLE_ACC);
   assign w_timeout = !w_accept && (r_idle_cnt == c_IDLE_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seg_q    <= 8'h00;
         r_stab_cnt <= '0;
         r_idle_cnt <= '0;
      end else begin
         r_seg_q <= seg_in;
         if (seg_in != r_seg_q)
            r_stab_cnt <= '0;
         else if (r_stab_cnt != c_SETTLE_MAX)
            r_stab_cnt <= r_stab_cnt + 1'b1;
         if (w_accept)
            r_idle_cnt <= '0;
         else if (r_idle_cnt != c_IDLE_MAX)
            r_idle_cnt <= r_idle_cnt + 1'b1;
      end
   end

   always_comb begin
      w_code = ERR_CODE;
      case (seg_in[6:0])
         7'h3F:   w_code = 4'd0;
         7'h06:   w_code = 4'd1;
         7'h5B:   w_code = 4'd2;
         7'h4F:   w_code = 4'd3;
         7'h66:   w_code = 4'd4;
         7'h6D:   w_code = 4'd5;
         7'h7D:   w_code = 4'd6;
         7'h07:   w_code = 4'd7;
         7'h7F:   w_code = 4'd8;
         7'h6F:   w_code = 4'd9;
         7'h00:   w_code = BLANK_CODE;
         default: w_code = ERR_CODE;
      endcase
   end

   // Accept outranks timeout when both land on the same edge.
   always_comb begin
      w_next = r_state;
      w_upd  = 1'b0;
      if (w_accept) begin
         case (r_state)
            S_IDLE:   w_next = w_sel ? S_HAVE_T : S_HAVE_O;
            S_HAVE_T: if (!w_sel) begin w_next = S_VALID; w_upd = 1'b1; end
            S_HAVE_O: if (w_sel)  begin w_next = S_VALID; w_upd = 1'b1; end
            S_VALID:  w_upd = w_sel ? (w_code != r_tens) : (w_code != r_ones);
            default:  w_next = S_IDLE;
         endcase
      end else if (w_timeout) begin
         w_next = S_IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_tens    <= BLANK_CODE;
         r_ones    <= BLANK_CODE;
         r_valid   <= 1'b0;
         r_upd     <= 1'b0;
         r_bad     <= 1'b0;
         r_bad_cnt <= 8'h00;
      end else begin
         r_state <= w_next;
         r_valid <= (w_next == S_VALID);
         r_upd   <= w_upd;
         r_bad   <= w_accept && (w_code == ERR_CODE);
         if (w_accept) begin
            if (w_sel) r_tens <= w_code;
            else       r_ones <= w_code;
            if ((w_code == ERR_CODE) && (r_bad_cnt != 8'hFF))
               r_bad_cnt <= r_bad_cnt + 1'b1;
         end
      end
   end

   assign tens_out     = r_tens;
   assign ones_out     = r_ones;
   assign value_valid  = r_valid;
   assign update_pulse = r_upd;
   assign bad_pulse    = r_bad;
   assign bad_count    = r_bad_cnt;

endmodule
`default_nettype wire
